// File: rtl/bin16_to_dec4_seq_if.sv
// Handshake and data bundle between the period/frequency meter (master)
// and the binary-to-BCD converter (slave).
//
// Handshake: the master raises start together with a valid bin; the slave
// accepts them on the first rising clk edge where it is idle (busy=0).
// start while busy=1 is dropped, not queued.
// done is a one-cycle pulse. While done is high, dec/ovf/blank hold the new
// result, and they stay stable until the next done pulse.
// fsm_state mirrors the converter FSM for checkers: 0=IDLE, 1=SHIFT, 2=DONE.
interface bin16_to_dec4_seq_if #(
  parameter int BIN_W = 16
);
  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic             done;
  logic [15:0]      dec;
  logic             ovf;
  logic [3:0]       blank;
  logic [1:0]       fsm_state;

  modport master (
    output start, bin,
    input  busy, done, dec, ovf, blank, fsm_state
  );

  modport slave (
    input  start, bin,
    output busy, done, dec, ovf, blank, fsm_state
  );
endinterface

// File: rtl/bin16_to_dec4_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock).
// Values above 9999 are flagged in ovf and the display saturates to 9999.
// Optional macro B2D_BLANK_EN registers a leading-zero blank mask on the
// DONE edge; without it, blank is tied to zero and no extra logic is built.
module bin16_to_dec4_seq #(
  parameter int BIN_W = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  bin16_to_dec4_seq_if.slave       bus
);

  localparam int SR_W = BIN_W + 16;
  localparam logic [BIN_W-1:0] MAX_DEC  = BIN_W'(9999);
  localparam logic [4:0]       LAST_CNT = 5'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [SR_W-1:0] sr;
  logic [SR_W-1:0] sr_shifted;
  logic [15:0]     bcd_adj;
  logic [15:0]     bcd_res;
  logic [4:0]      cnt;
  logic            ov_pend;
  logic            load;
  logic            shift_en;
  logic            finish;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: IDLE -> SHIFT on start, BIN_W shifts, one DONE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_SHIFT;
      S_SHIFT: if (cnt == LAST_CNT) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output/strobe decode from the current state.
  always_comb begin
    load      = (state == S_IDLE) && bus.start;
    shift_en  = (state == S_SHIFT);
    finish    = (state == S_DONE);
    bus.busy  = (state != S_IDLE);
  end

  assign bus.fsm_state = state;

  // Add 3 to every BCD nibble >= 5, then shift the whole register left.
  always_comb begin
    bcd_adj = sr[SR_W-1 -: 16];
    for (int i = 0; i < 4; i++) begin
      if (bcd_adj[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_adj[i*4 +: 4] + 4'd3;
    end
    sr_shifted = {bcd_adj[14:0], sr[BIN_W-1:0], 1'b0};
  end

  assign bcd_res = sr[SR_W-1 -: 16];

  // Shift register, bit counter and pending-overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      cnt     <= '0;
      ov_pend <= 1'b0;
    end else if (load) begin
      sr      <= {16'h0000, bus.bin};
      cnt     <= '0;
      ov_pend <= (bus.bin > MAX_DEC);
    end else if (shift_en) begin
      sr      <= sr_shifted;
      cnt     <= cnt + 5'd1;
    end
  end

  // Result registers: updated only on the DONE edge, done pulses once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.done <= 1'b0;
      bus.dec  <= 16'h0000;
      bus.ovf  <= 1'b0;
    end else begin
      bus.done <= finish;
      if (finish) begin
        bus.dec <= ov_pend ? 16'h9999 : bcd_res;
        bus.ovf <= ov_pend;
      end
    end
  end

`ifdef B2D_BLANK_EN
  logic [3:0] blank_r;

  // Leading-zero mask; units never blanked, saturated results never blanked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_r <= 4'b0000;
    end else if (finish) begin
      if (ov_pend) begin
        blank_r <= 4'b0000;
      end else begin
        blank_r[3] <= (bcd_res[15:12] == 4'd0);
        blank_r[2] <= (bcd_res[15:12] == 4'd0) && (bcd_res[11:8] == 4'd0);
        blank_r[1] <= (bcd_res[15:12] == 4'd0) && (bcd_res[11:8] == 4'd0) &&
                      (bcd_res[7:4] == 4'd0);
        blank_r[0] <= 1'b0;
      end
    end
  end

  assign bus.blank = blank_r;
`else
  assign bus.blank = 4'b0000;
`endif

endmodule

// File: tb/tb_bin16_to_dec4_seq.sv
// Directed bench for bin16_to_dec4_seq (BIN_W=16). Blank expectations follow
// B2D_BLANK_EN the same way the design does.
module tb_bin16_to_dec4_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   done_cnt;
  logic [15:0] exp_q[$];

  bin16_to_dec4_seq_if #(.BIN_W(16)) bif ();

  bin16_to_dec4_seq #(.BIN_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every done pulse, sampled away from the active edge.
  always @(negedge clk) if (bif.done) done_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  // ---------------- checker ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] blank_exp(input logic [3:0] b);
`ifdef B2D_BLANK_EN
    return b;
`else
    return 4'b0000;
`endif
  endfunction

  // ---------------- drivers ----------------
  // One conversion: pulse start, measure latency and busy span, check result.
  task automatic run_conv(input string tag, input logic [15:0] v, input logic [15:0] e_dec,
                          input logic e_ovf, input logic [3:0] e_blank);
    int k;
    int busy_n;
    @(negedge clk);
    bif.start = 1'b1;
    bif.bin   = v;
    @(posedge clk);           // E0
    @(negedge clk);
    bif.start = 1'b0;
    bif.bin   = 16'hDEAD;     // must not disturb the running conversion
    k = 0;
    busy_n = 0;
    while (!bif.done && k < 40) begin
      if (bif.busy) busy_n++;
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    check_val({tag, "_latency"}, k, 17);
    check_val({tag, "_busy_cycles"}, busy_n, 17);
    check_val({tag, "_busy_at_done"}, bif.busy, 0);
    check_val({tag, "_dec"}, bif.dec, e_dec);
    check_val({tag, "_ovf"}, bif.ovf, e_ovf);
    check_val({tag, "_blank"}, bif.blank, blank_exp(e_blank));
    @(negedge clk);
    check_val({tag, "_done_one_cycle"}, bif.done, 0);
    check_val({tag, "_dec_hold"}, bif.dec, e_dec);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    int k;
    int last_k;
    int n_seen;
    n_checks  = 0;
    n_errors  = 0;
    done_cnt  = 0;
    bif.start = 1'b0;
    bif.bin   = 16'h0000;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);

    check_val("rst_busy", bif.busy, 0);
    check_val("rst_done", bif.done, 0);
    check_val("rst_dec", bif.dec, 16'h0000);
    check_val("rst_ovf", bif.ovf, 0);
    check_val("rst_blank", bif.blank, 4'b0000);
    check_val("rst_state", bif.fsm_state, 2'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Directed vectors with hand-computed BCD results.
    run_conv("v1234",  16'd1234,  16'h1234, 1'b0, 4'b0000);
    run_conv("v9999",  16'd9999,  16'h9999, 1'b0, 4'b0000);
    run_conv("v10000", 16'd10000, 16'h9999, 1'b1, 4'b0000);
    run_conv("v65535", 16'd65535, 16'h9999, 1'b1, 4'b0000);
    run_conv("v0",     16'd0,     16'h0000, 1'b0, 4'b1110);
    run_conv("v45",    16'd45,    16'h0045, 1'b0, 4'b1100);
    run_conv("v100",   16'd100,   16'h0100, 1'b0, 4'b1000);
    run_conv("v7",     16'd7,     16'h0007, 1'b0, 4'b1110);
    run_conv("v5678",  16'd5678,  16'h5678, 1'b0, 4'b0000);
    run_conv("v1234b", 16'd1234,  16'h1234, 1'b0, 4'b0000);

    // Reset mid-conversion: asserted just after edge E5, no done afterwards.
    @(negedge clk);
    bif.start = 1'b1;
    bif.bin   = 16'd4321;
    @(posedge clk);           // E0
    @(negedge clk);
    bif.start = 1'b0;
    repeat (5) @(posedge clk); // E5
    #1 rst_n = 1'b0;
    #1;
    check_val("midrst_busy", bif.busy, 0);
    check_val("midrst_dec", bif.dec, 16'h0000);
    check_val("midrst_ovf", bif.ovf, 0);
    check_val("midrst_done", bif.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    idle_cycles(30);
    check_val("midrst_no_done", done_cnt - d0, 0);
    check_val("midrst_dec_kept", bif.dec, 16'h0000);

    // Handshake: start re-pulsed at E3 and at the busy-falling edge E17.
    d0 = done_cnt;
    @(negedge clk);
    bif.start = 1'b1;
    bif.bin   = 16'd2345;
    @(posedge clk);           // E0
    @(negedge clk);
    bif.start = 1'b0;
    @(posedge clk);           // E1
    @(negedge clk);
    @(posedge clk);           // E2
    @(negedge clk);
    bif.start = 1'b1;
    bif.bin   = 16'd5555;
    @(posedge clk);           // E3
    @(negedge clk);
    bif.start = 1'b0;
    repeat (13) begin         // E4 .. E16
      @(posedge clk);
      @(negedge clk);
    end
    bif.start = 1'b1;
    bif.bin   = 16'd6666;
    @(posedge clk);           // E17
    @(negedge clk);
    bif.start = 1'b0;
    check_val("hs_done_at_e17", bif.done, 1);
    idle_cycles(30);
    check_val("hs_one_done", done_cnt - d0, 1);
    check_val("hs_busy_idle", bif.busy, 0);
    check_val("hs_dec", bif.dec, 16'h2345);

    // Held start: free-running conversions every 18 cycles, bin changed
    // mid-conversion only affects the following conversion.
    exp_q.push_back(16'h0321);
    exp_q.push_back(16'h8765);
    exp_q.push_back(16'h8765);
    @(negedge clk);
    bif.start = 1'b1;
    bif.bin   = 16'd321;
    k = -1;
    last_k = 0;
    n_seen = 0;
    while (n_seen < 3 && k < 120) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (k == 5) bif.bin = 16'd8765;
      if (bif.done) begin
        if (n_seen == 0) check_val("held_first_latency", k, 17);
        else             check_val("held_spacing", k - last_k, 18);
        last_k = k;
        n_seen++;
        if (exp_q.size() > 0) check_val("held_dec", bif.dec, exp_q.pop_front());
      end
    end
    bif.start = 1'b0;
    check_val("held_done_count", n_seen, 3);
    check_val("held_queue_empty", exp_q.size(), 0);
    idle_cycles(25);
    check_val("held_stopped_busy", bif.busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bin16_to_dec4_seq.md
Name: bin16_to_dec4_seq

Overview:
- Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
- Sits downstream of the period/frequency meter. It takes the 16-bit binary measurement result and produces 4 packed BCD digits for the 4-digit 7-segment display path.
- Flags values above 9999 as overflow and saturates the display to 9999.
- Start/busy/done handshake, so the meter can launch a conversion whenever a new measurement is ready.

Parameters:
- BIN_W, 16, input binary width in bits. Legal range is 14..16; unused upper bits of bin are ignored.

Ports:
- clk  in  1  system clock; all flops on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  conversion request, sampled on clk; one-cycle pulse or level
- bin  in  BIN_W  binary value; sampled only on the edge that accepts start
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse; dec and ovf are valid and updated
- dec  out  16  packed BCD {thousands, hundreds, tens, units}; holds the last result
- ovf  out  1  last converted value exceeded 9999
- blank  out  4  leading-zero blank mask, bit3 = thousands (see Optional Feature)

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; busy=0, done=0, dec=16'h0000, ovf=0, blank=4'b0000; internal shift register and bit counter cleared.
- Releasing reset takes effect on the next clk edge. Reset asserted mid-conversion aborts it; no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE: on an edge with start=1:
  - Load shift register {BCD=0, bin}.
  - Capture ov_pend = (bin > 9999).
  - Clear the bit counter, go to SHIFT, set busy=1.
  - Call this edge E0.
- SHIFT: on each edge:
  - Add 3 to every BCD nibble that is >= 5.
  - Then shift the whole register left by 1.
  - Increment the counter.
  - After BIN_W shifts (edge E_BIN_W), go to DONE.
- DONE: on edge E_(BIN_W+1):
  - dec <= ov_pend ? 16'h9999 : BCD result.
  - ovf <= ov_pend.
  - done <= 1 for exactly one cycle; busy <= 0.
  - Go to IDLE.
- Latency: done is high in the clock cycle following edge E0 + BIN_W + 1. For BIN_W=16, that is 17 edges after start is accepted.
- Minimum start-to-start spacing is BIN_W+2 cycles.
- start while busy=1 (SHIFT or DONE) is ignored, not queued. start on the edge where busy falls is also ignored.
- A start held high continuously restarts a conversion on the first IDLE edge, i.e. free-running conversions.
- Changes on bin while busy do not affect the result.
- dec, ovf and blank change only on the DONE edge or on reset; they are stable between done pulses.
- Values exactly 9999: ovf=0, dec=16'h9999. 10000: ovf=1, dec=16'h9999. 0: dec=16'h0000, ovf=0.
- BCD nibble arithmetic is 4-bit; add-3 never carries out of a nibble because the input is < 10000 or the result is overridden by saturation.

Optional Feature:
- Macro B2D_BLANK_EN.
- Defined: on the DONE edge, blank is registered as the leading-zero mask.
  - blank[3] = thousands==0.
  - blank[2] = blank[3] & hundreds==0.
  - blank[1] = blank[2] & tens==0.
  - blank[0] = 0 always; the units digit is never blanked.
  - When ovf=1, blank=4'b0000.
- Not defined: blank is tied to 4'b0000 and no extra logic is built. Port list is identical in both builds.

Test Plan:
- Reset mid-conversion: start with bin=1234, pull rst_n low at edge E5 -> busy=0, dec=16'h0000, ovf=0 immediately; no done pulse follows.
- Nominal: bin=16'd1234, start pulse -> busy high 17 cycles, then done one cycle with dec=16'h1234, ovf=0; blank=4'b0000 with B2D_BLANK_EN.
- Boundary: bin=9999 -> dec=16'h9999, ovf=0. bin=10000 -> dec=16'h9999, ovf=1. bin=65535 -> dec=16'h9999, ovf=1, blank=0.
- Zero and leading zeros (B2D_BLANK_EN): bin=0 -> dec=16'h0000, blank=4'b1110. bin=45 -> dec=16'h0045, blank=4'b1100.
- Handshake: start re-pulsed at E3 and at the busy-falling edge -> both ignored, exactly one done. start held high -> done every 18 cycles; bin changed mid-conversion does not alter that conversion's dec.
